// File: rtl/addtree_pkg.sv
// rtl/addtree_pkg.sv - shared width, state encoding and constants for the add-tree accumulator
package addtree_pkg;

    localparam int ADDTREE_W = 64;

    localparam logic [ADDTREE_W-1:0] ADDTREE_ONES = '1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } acc_state_e;

endpackage

// File: rtl/addtree_acc_add.sv
// rtl/addtree_acc_add.sv - W-bit group adder returning {sum, sat}
// Saturating when ADDTREE_ACC_SAT_EN is defined, modulo 2^W otherwise.
module addtree_acc_add
    import addtree_pkg::*;
#(
    parameter int W = ADDTREE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

`ifdef ADDTREE_ACC_SAT_EN
    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    assign sat  = full[W];
`else
    assign sum = a + b;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/addtree_accum.sv
// rtl/addtree_accum.sv - reduces each group of N add-tree sums into one W-bit total
// Optional saturating arithmetic via ADDTREE_ACC_SAT_EN; out_sat reads 0 when it is undefined.
module addtree_accum
    import addtree_pkg::*;
#(
    parameter int W  = ADDTREE_W,
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    acc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          sat_q, sat_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_sat_q, out_sat_d;

    logic [W-1:0]  add_a;
    logic [W-1:0]  add_sum;
    logic          add_sat;

    // The first beat of a group starts from zero so stale acc/sat never leak in.
    assign add_a = (cnt_q == '0) ? '0 : acc_q;

    addtree_acc_add #(.W(W)) u_add (
        .a   (add_a),
        .b   (in_data),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = add_sum;
                    sat_d = ((cnt_q == '0) ? 1'b0 : sat_q) | add_sat;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d      = '0;
                        out_data_d = add_sum;
                        out_sat_d  = sat_d;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_addtree_accum.sv
// tb/tb_addtree_accum.sv - self-checking bench for addtree_accum (N=4), both ADDTREE_ACC_SAT_EN builds
module tb_addtree_accum;

    localparam int W = 64;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sat;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] grp[$];
    bit           m_done = 1'b0;
    logic [W-1:0] m_out = '0;
    bit           m_sat = 1'b0;

    addtree_accum #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Group total from the accepted beats using plain arithmetic.
    task automatic ref_total(output logic [W-1:0] tot, output bit s);
        logic [W:0] t;
        tot = '0;
        s   = 1'b0;
        foreach (grp[i]) begin
            t = {1'b0, tot} + {1'b0, grp[i]};
`ifdef ADDTREE_ACC_SAT_EN
            if (t[W]) begin
                tot = '1;
                s   = 1'b1;
            end else begin
                tot = t[W-1:0];
            end
`else
            tot = t[W-1:0];
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_in_ready"},  W'(in_ready),  W'(!m_done));
        chk({tag, "_out_valid"}, W'(out_valid), W'(m_done));
        chk({tag, "_out_data"},  out_data,      m_out);
        chk({tag, "_out_sat"},   W'(out_sat),   W'(m_sat));
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        check_outputs("cyc");
        @(posedge clk);
        if (!m_done) begin
            if (v) begin
                grp.push_back(d);
                if (grp.size() == N) begin
                    ref_total(m_out, m_sat);
                    grp.delete();
                    m_done = 1'b1;
                end
            end
        end else if (ordy) begin
            m_done = 1'b0;
        end
    endtask

    // Reset asserted 2 time units after a quiet clock edge, checked before the next edge.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_outputs({tag, "_pre"});
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        grp.delete();
        m_done = 1'b0;
        m_out  = '0;
        m_sat  = 1'b0;
        check_outputs({tag, "_async"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] exp_ones;
        ones = '1;

        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // 1,2,3,4 back to back
        step(1, 64'd1, 1);
        step(1, 64'd2, 1);
        step(1, 64'd3, 1);
        step(1, 64'd4, 1);
        step(0, 64'd0, 1);
        chk("t1_total", out_data, 64'd10);
        step(0, 64'd0, 1);

        // four all-ones beats: wrap vs saturate
        for (int i = 0; i < N; i++) step(1, ones, 1);
        step(0, 64'd0, 0);
`ifdef ADDTREE_ACC_SAT_EN
        exp_ones = ones;
        chk("t2_sat_flag", W'(out_sat), 64'd1);
`else
        exp_ones = 64'hFFFF_FFFF_FFFF_FFFC;
        chk("t2_sat_flag", W'(out_sat), 64'd0);
`endif
        chk("t2_total", out_data, exp_ones);
        step(0, 64'd0, 1);

        // backpressure: held total, extra beats refused
        step(1, 64'd10, 0);
        step(1, 64'd20, 0);
        step(1, 64'd30, 0);
        step(1, 64'd40, 0);
        for (int i = 0; i < 5; i++) step(1, 64'd999, 0);
        chk("t3_total", out_data, 64'd100);
        step(1, 64'd999, 1);
        for (int i = 0; i < N; i++) step(1, 64'd1, 1);
        step(0, 64'd0, 1);
        chk("t3_next_total", out_data, 64'd4);

        // gapped beats
        step(1, 64'd7, 1);
        step(0, 64'd123, 1);
        step(0, 64'd456, 1);
        step(1, 64'd8, 1);
        step(0, 64'd789, 1);
        step(1, 64'd9, 1);
        step(1, 64'd10, 1);
        step(0, 64'd0, 1);
        chk("t4_total", out_data, 64'd34);

        // reset mid-group discards the partial sum
        step(1, 64'd5, 1);
        step(1, 64'd5, 1);
        mid_reset("t5_rst");
        for (int i = 0; i < N; i++) step(1, 64'd5, 1);
        step(0, 64'd0, 0);
        chk("t5_total", out_data, 64'd20);

        // reset while a total is pending
        mid_reset("t6_rst");
        step(0, 64'd0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 3) == 0) d = {32'hFFFF_FFFF, $urandom()};
            else                           d = {$urandom(), $urandom()};
            step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0));
        end

        step(0, 64'd0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addtree_accum.md
Name: addtree_accum

Overview:
Downstream stage of the 64-bit add tree: consumes the stream of registered sums leaving the final add stage and reduces each group of N consecutive sums into one 64-bit total. Valid/ready on both sides. Wrap-around arithmetic by default; optional saturation. Output feeds the result collector / host readout.

Parameters:
W, 64, data width of input sums and output total
N, 8, words per group (N >= 2)
CW, $clog2(N), beat-counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  in_data valid (driven in step with the upstream add stage's registered q)
in_ready  output  1  accumulator can take a beat
in_data  input  W  partial sum from the add tree
out_valid  output  1  group total available
out_ready  input  1  consumer accepts total
out_data  output  W  group total
out_sat  output  1  total saturated (0 when feature compiled out)

Behaviour:
- Reset (reset=0, async): state=ACC, cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0, in_ready=1 after release.
- FSM, two states:
  - ACC: in_ready=1, out_valid=0. Beat = in_valid & in_ready. On beat with cnt==0: acc <= in_data. On beat with cnt>0: acc <= acc + in_data (mod 2^W, or saturating). cnt <= cnt+1.
  - ACC, beat with cnt==N-1: out_data <= final sum (acc+in_data), out_sat <= sticky sat, cnt <= 0, next state DONE.
  - DONE: out_valid=1, in_ready=0. out_data/out_sat held stable while out_ready=0. On out_valid & out_ready -> ACC, acc cleared, sat flag cleared.
- Latency: out_valid rises 1 cycle after the Nth accepted beat. Min period N+1 cycles per group.
- Idle cycles (in_valid=0) in ACC: no state change; gaps anywhere in a group are legal.
- in_data ignored when in_ready=0; upstream must hold it (no drop, no double count).
- out_data/out_sat only change on entry to DONE or at reset; the value after handshake is retained (not zeroed) until next group completes.
- Reset mid-group: partial accumulation discarded, cnt=0; next beat starts a new group.
- Reset while out_valid=1: total lost, out_valid=0 immediately (async).
- Wrap mode: intermediate and final sums truncated to W bits, no flag.

Optional Feature:
ADDTREE_ACC_SAT_EN
- Defined: each add is unsigned saturating; if carry-out of W bits, result = all ones and a sticky sat flag is set for the group; out_sat = flag at DONE. Once saturated, the group stays all-ones.
- Undefined: modulo-2^W addition, out_sat tied to 0. Port list identical in both builds.

Decomposition:
- addtree_pkg: W default, state encoding (ACC=1'b0, DONE=1'b1), all-ones constant.
- One sub-module natural: addtree_acc_add, combinational W-bit adder returning {sum, sat}; saturation logic inside it under ADDTREE_ACC_SAT_EN, plain add otherwise.

Test Plan:
- N=4, beats 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=10, out_sat=0; in_ready=0 that cycle, 1 again after.
- N=4, four beats 64'hFFFF_FFFF_FFFF_FFFF -> wrap build: out_data=64'hFFFF_FFFF_FFFF_FFFC, out_sat=0; ADDTREE_ACC_SAT_EN build: out_data=all ones, out_sat=1.
- Group 10,20,30,40 with out_ready=0 for 5 cycles -> out_data=100 held stable, in_ready=0, extra in_valid beats not consumed; out_ready=1 -> handshake, next group 1,1,1,1 gives 4.
- in_valid toggled 1,0,0,1,0,1,1 carrying 7,x,x,8,x,9,10 -> only valid beats counted, out_data=34.
- Beats 5,5 then reset=0 one cycle, then 5,5,5,5 -> single output 20; no output for the aborted group.
- reset=0 asserted while out_valid=1 -> out_valid, out_data, out_sat=0 asynchronously, before the next clock edge.
